// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared types and default widths for the count sequencer
package count_seq_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_LOOP_W = 4;

  typedef enum logic [1:0] {
    UP_ONCE   = 2'b00,
    DOWN_ONCE = 2'b01,
    PINGPONG  = 2'b10,
    FREE_WRAP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_UP   = 2'b01,
    RUN_DOWN = 2'b10
  } state_e;

endpackage

// File: rtl/count_seq_core.sv
// rtl/count_seq_core.sv - up/down count register with load, enable and direction
module count_seq_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  // Load has priority over stepping; the sequencer never asks for both at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en) begin
      if (up) begin
        count_q <= count_q + WIDTH'(1);
      end else begin
        count_q <= count_q - WIDTH'(1);
      end
    end
  end

  assign count = count_q;

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - job sequencer around the up/down count register; COUNT_SEQ_PAUSE_EN adds a pause input
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOOP_W = DEF_LOOP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
`ifdef COUNT_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic [LOOP_W-1:0] loops,
  output logic [WIDTH-1:0]  count,
  output logic              dir,
  output logic              busy,
  output logic              at_lim,
  output logic              done,
  output logic              cfg_err
);

`ifndef COUNT_SEQ_PAUSE_EN
  logic pause;
  assign pause = 1'b0;
`endif

  state_e            state, state_next;
  logic              dir_q, dir_next;
  logic [LOOP_W-1:0] loop_cnt, loop_next, loop_inc;
  logic              done_q, done_next;
  logic              cfg_err_q, cfg_err_next;
  logic              accept;

  // Job parameters captured at start so input changes mid-job have no effect.
  mode_e             mode_s;
  logic [WIDTH-1:0]  lo_s, hi_s;
  logic [LOOP_W-1:0] loops_s;

  logic              core_load, core_en, core_up;
  logic [WIDTH-1:0]  core_load_val;

  count_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load),
    .load_val (core_load_val),
    .en       (core_en),
    .up       (core_up),
    .count    (count)
  );

  // State, direction, loop counter and the registered status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= 1'b1;
      loop_cnt  <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_next;
      dir_q     <= dir_next;
      loop_cnt  <= loop_next;
      done_q    <= done_next;
      cfg_err_q <= cfg_err_next;
    end
  end

  // Capture the job parameters on an accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_s  <= UP_ONCE;
      lo_s    <= '0;
      hi_s    <= '0;
      loops_s <= '0;
    end else if (accept) begin
      mode_s  <= mode_e'(mode);
      lo_s    <= lo_lim;
      hi_s    <= hi_lim;
      loops_s <= loops;
    end
  end

  // Next-state, count-register control and pulse generation.
  always_comb begin
    state_next    = state;
    dir_next      = dir_q;
    loop_next     = loop_cnt;
    loop_inc      = loop_cnt + LOOP_W'(1);
    done_next     = 1'b0;
    cfg_err_next  = 1'b0;
    accept        = 1'b0;
    core_load     = 1'b0;
    core_load_val = count;
    core_en       = 1'b0;
    core_up       = dir_q;

    case (state)
      IDLE: begin
        // stop wins over start in the same cycle, including config checking
        if (start && !stop) begin
          if (lo_lim < hi_lim) begin
            accept    = 1'b1;
            core_load = 1'b1;
            loop_next = '0;
            if (mode_e'(mode) == DOWN_ONCE) begin
              core_load_val = hi_lim;
              state_next    = RUN_DOWN;
              dir_next      = 1'b0;
            end else begin
              core_load_val = lo_lim;
              state_next    = RUN_UP;
              dir_next      = 1'b1;
            end
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end

      RUN_UP: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!pause) begin
          if (count != hi_s) begin
            core_en = 1'b1;
            core_up = 1'b1;
          end else begin
            case (mode_s)
              PINGPONG: begin
                // turn around without dwelling on the upper limit
                state_next = RUN_DOWN;
                dir_next   = 1'b0;
                core_en    = 1'b1;
                core_up    = 1'b0;
              end
              FREE_WRAP: begin
                core_load     = 1'b1;
                core_load_val = lo_s;
              end
              default: begin
                state_next = IDLE;
                done_next  = 1'b1;
              end
            endcase
          end
        end
      end

      RUN_DOWN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!pause) begin
          if (count != lo_s) begin
            core_en = 1'b1;
            core_up = 1'b0;
          end else if (mode_s == PINGPONG) begin
            // one round trip finished; loops of 0 means run forever
            loop_next = loop_inc;
            if ((loops_s != '0) && (loop_inc == loops_s)) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = RUN_UP;
              dir_next   = 1'b1;
              core_en    = 1'b1;
              core_up    = 1'b1;
            end
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state != IDLE);
  assign dir     = dir_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign at_lim  = ((state == RUN_UP) && (count == hi_s)) ||
                   ((state == RUN_DOWN) && (count == lo_s));

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - scoreboard bench for count_sequencer; define COUNT_SEQ_PAUSE_EN to cover pause
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int W  = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset, start, stop;
  logic [1:0]    mode;
  logic [W-1:0]  lo_lim, hi_lim;
  logic [LW-1:0] loops;
  logic [W-1:0]  count;
  logic          dir, busy, at_lim, done, cfg_err;
`ifdef COUNT_SEQ_PAUSE_EN
  logic          pause;
`endif

  // observed = {count, dir, busy, at_lim, done, cfg_err}
  logic [8:0] obs;
  assign obs = {count, dir, busy, at_lim, done, cfg_err};

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         d;
    logic         lim;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] prev_cnt;
  logic         prev_dir;

  always #5 clk = ~clk;

  count_sequencer #(.WIDTH(W), .LOOP_W(LW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
`ifdef COUNT_SEQ_PAUSE_EN
    .pause   (pause),
`endif
    .mode    (mode),
    .lo_lim  (lo_lim),
    .hi_lim  (hi_lim),
    .loops   (loops),
    .count   (count),
    .dir     (dir),
    .busy    (busy),
    .at_lim  (at_lim),
    .done    (done),
    .cfg_err (cfg_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: pushes the expected per-cycle (count, dir, at_lim) of a job.
  // Returns 1 when the job is expected to complete within max_steps.
  function automatic bit model(input logic [1:0] m, input logic [W-1:0] lo,
                               input logic [W-1:0] hi, input logic [LW-1:0] lps,
                               input int max_steps);
    logic [W-1:0]  c;
    logic          up;
    logic [LW-1:0] lp;
    bit            fin;
    int            n;
    c = (m == 2'b01) ? hi : lo;
    up = (m != 2'b01);
    lp = '0;
    fin = 1'b0;
    n = 0;
    while (!fin && n < max_steps) begin
      sb.push_back('{cnt: c, d: up, lim: up ? (c == hi) : (c == lo)});
      n++;
      if (up) begin
        if (c != hi) c = c + 1'b1;
        else if (m == 2'b00) fin = 1'b1;
        else if (m == 2'b10) begin up = 1'b0; c = hi - 1'b1; end
        else c = lo;
      end else begin
        if (c != lo) c = c - 1'b1;
        else if (m == 2'b01) fin = 1'b1;
        else begin
          lp = lp + 1'b1;
          if (lps != 0 && lp == lps) fin = 1'b1;
          else begin up = 1'b1; c = lo + 1'b1; end
        end
      end
    end
    return fin;
  endfunction

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    lo_lim = '0; hi_lim = '0; loops = '0;
`ifdef COUNT_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    tick; tick;
    checks++;
    if (obs !== 9'b0000_1_0_0_0_0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs, 9'b0000_1_0_0_0_0);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (obs !== 9'b0000_1_0_0_0_0) begin
      errors++;
      $display("FAIL post_reset_idle: got %b want %b", obs, 9'b0000_1_0_0_0_0);
    end
    prev_cnt = '0; prev_dir = 1'b1;
  endtask

  // UP_ONCE / DOWN_ONCE, with start held and limits scrambled mid-job.
  task automatic test_once_modes;
    logic [1:0]   m_t [3] = '{2'b00, 2'b01, 2'b00};
    logic [W-1:0] lo_t[3] = '{4'd2, 4'd3, 4'd0};
    logic [W-1:0] hi_t[3] = '{4'd5, 4'd6, 4'd15};
    logic [W-1:0] last;
    bit           fin;
    for (int j = 0; j < 3; j++) begin
      mode = m_t[j]; lo_lim = lo_t[j]; hi_lim = hi_t[j]; loops = '0;
      fin = model(m_t[j], lo_t[j], hi_t[j], '0, 64);
      last = sb[$].cnt;
      start = 1'b1;
      tick;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs !== {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL once_step job%0d: got %b want %b", j, obs, {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0});
        end
        if (sb.size() == 0) start = 1'b0;
        else begin
          lo_lim = W'($urandom); hi_lim = W'($urandom); mode = 2'($urandom);
        end
        tick;
      end
      checks++;
      if (!fin || obs !== {last, m_t[j] != 2'b01, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL once_done job%0d: got %b want %b", j, obs, {last, m_t[j] != 2'b01, 4'b0010});
      end
      tick;
      checks++;
      if (obs !== {last, m_t[j] != 2'b01, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL once_after job%0d: got %b want %b", j, obs, {last, m_t[j] != 2'b01, 4'b0000});
      end
      prev_cnt = last; prev_dir = (m_t[j] != 2'b01);
    end
  endtask

  task automatic test_pingpong;
    logic [W-1:0]  lo_t[2] = '{4'd1, 4'd0};
    logic [W-1:0]  hi_t[2] = '{4'd3, 4'd15};
    logic [LW-1:0] lp_t[2] = '{4'd2, 4'd1};
    logic [W-1:0]  last;
    bit            fin;
    for (int j = 0; j < 2; j++) begin
      mode = 2'b10; lo_lim = lo_t[j]; hi_lim = hi_t[j]; loops = lp_t[j];
      fin = model(2'b10, lo_t[j], hi_t[j], lp_t[j], 200);
      last = sb[$].cnt;
      start = 1'b1;
      tick;
      start = 1'b0;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs !== {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL pingpong_step job%0d: got %b want %b", j, obs, {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0});
        end
        tick;
      end
      checks++;
      if (!fin || obs !== {last, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL pingpong_done job%0d: got %b want %b", j, obs, {last, 5'b00010});
      end
      tick;
      prev_cnt = last; prev_dir = 1'b0;
    end
  endtask

  task automatic test_free_wrap;
    logic [W-1:0] last;
    bit           fin;
    mode = 2'b11; lo_lim = 4'd14; hi_lim = 4'd15; loops = '0;
    fin = model(2'b11, 4'd14, 4'd15, '0, 20);
    last = sb[$].cnt;
    checks++;
    if (fin) begin
      errors++;
      $display("FAIL free_wrap_model: got completion want none");
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL free_wrap_step: got %b want %b", obs, {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0});
      end
      if (sb.size() == 0) stop = 1'b1;
      tick;
    end
    stop = 1'b0;
    checks++;
    if (obs !== {last, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL free_wrap_stop: got %b want %b", obs, {last, 5'b10000});
    end
    prev_cnt = last; prev_dir = 1'b1;
  endtask

  task automatic test_cfg_err;
    logic [W-1:0] lo_t[2] = '{4'd7, 4'd9};
    logic [W-1:0] hi_t[2] = '{4'd7, 4'd3};
    for (int j = 0; j < 2; j++) begin
      mode = 2'b00; lo_lim = lo_t[j]; hi_lim = hi_t[j];
      start = 1'b1;
      tick;
      start = 1'b0;
      checks++;
      if (obs !== {prev_cnt, prev_dir, 4'b0001}) begin
        errors++;
        $display("FAIL cfg_err_pulse case%0d: got %b want %b", j, obs, {prev_cnt, prev_dir, 4'b0001});
      end
      tick;
      checks++;
      if (obs !== {prev_cnt, prev_dir, 4'b0000}) begin
        errors++;
        $display("FAIL cfg_err_clear case%0d: got %b want %b", j, obs, {prev_cnt, prev_dir, 4'b0000});
      end
    end
  endtask

  task automatic test_stop_priority;
    mode = 2'b00; lo_lim = 4'd2; hi_lim = 4'd5;
    start = 1'b1; stop = 1'b1;
    tick;
    start = 1'b0; stop = 1'b0;
    checks++;
    if (obs !== {prev_cnt, prev_dir, 4'b0000}) begin
      errors++;
      $display("FAIL stop_beats_start: got %b want %b", obs, {prev_cnt, prev_dir, 4'b0000});
    end
    lo_lim = 4'd0; hi_lim = 4'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (obs !== {4'd0, 1'b1, 4'b1000}) begin
      errors++;
      $display("FAIL stop_job_first: got %b want %b", obs, {4'd0, 5'b11000});
    end
    tick;
    checks++;
    if (obs !== {4'd1, 1'b1, 4'b1100}) begin
      errors++;
      $display("FAIL stop_job_at_lim: got %b want %b", obs, {4'd1, 5'b11100});
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checks++;
    if (obs !== {4'd1, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL stop_beats_done: got %b want %b", obs, {4'd1, 5'b10000});
    end
    prev_cnt = 4'd1; prev_dir = 1'b1;
  endtask

  task automatic test_reset_mid_job;
    mode = 2'b10; lo_lim = 4'd4; hi_lim = 4'd9; loops = 4'd0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if (obs !== {4'd0, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid_job: got %b want %b", obs, {4'd0, 5'b10000});
    end
    tick;
    checks++;
    if (obs !== {4'd0, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL reset_mid_job_no_done: got %b want %b", obs, {4'd0, 5'b10000});
    end
    prev_cnt = 4'd0; prev_dir = 1'b1;
  endtask

`ifdef COUNT_SEQ_PAUSE_EN
  task automatic test_pause;
    bit fin;
    int i;
    mode = 2'b00; lo_lim = 4'd2; hi_lim = 4'd5; loops = '0;
    fin = model(2'b00, 4'd2, 4'd5, '0, 64);
    // three frozen cycles at count 3
    for (int k = 0; k < 3; k++) sb.insert(2, sb[1]);
    start = 1'b1;
    tick;
    start = 1'b0;
    i = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs !== {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL pause_step %0d: got %b want %b", i, obs, {e.cnt, e.d, 1'b1, e.lim, 1'b0, 1'b0});
      end
      pause = (i >= 1 && i <= 3);
      i++;
      tick;
    end
    pause = 1'b0;
    checks++;
    if (!fin || obs !== {4'd5, 1'b1, 4'b0010}) begin
      errors++;
      $display("FAIL pause_done: got %b want %b", obs, {4'd5, 5'b10010});
    end
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_once_modes;
    test_pingpong;
    test_free_wrap;
    test_cfg_err;
    test_stop_priority;
    test_reset_mid_job;
`ifdef COUNT_SEQ_PAUSE_EN
    test_pause;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
